// File: rtl/nibble_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_alu_seq
// Brief   : Nibble-serial add/sub sequencer driving an external 4-bit adder.
// Revision: 1.0
// ============================================================================
module nibble_serial_alu_seq #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   op_sub,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   output logic [3:0]             add_a,
   output logic [3:0]             add_b,
   output logic                   add_cin,
   input  logic [3:0]             add_sum,
   input  logic                   add_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   flag_c,
   output logic                   flag_z,
   output logic                   flag_v
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);
   localparam logic [CW-1:0] c_last = CW'(NIBBLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [1:0]    w_state_next;
   logic [CW-1:0] r_cnt;
   logic          r_carry;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic          r_sub;
   logic [W-1:0]  r_result;
   logic          r_c;
   logic          r_z;
   logic          r_v;
   logic          r_out_valid;
   logic [W-1:0]  w_result_next;
   logic          w_last;

   assign w_last = (r_cnt == c_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_RUN;
         S_RUN:   if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Adder ports are forced to zero outside RUN so the adder sees a quiet bus.
   always_comb begin
      in_ready = (r_state == S_IDLE);
      add_a    = 4'd0;
      add_b    = 4'd0;
      add_cin  = 1'b0;
      if (r_state == S_RUN) begin
         add_a   = r_a[4*r_cnt +: 4];
         add_b   = r_b[4*r_cnt +: 4] ^ {4{r_sub}};
         add_cin = (r_cnt == '0) ? r_sub : r_carry;
      end
   end

   always_comb begin
      w_result_next = r_result;
      w_result_next[4*r_cnt +: 4] = add_sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sub       <= 1'b0;
         r_result    <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_v         <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a   <= op_a;
                  r_b   <= op_b;
                  r_sub <= op_sub;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               r_result <= w_result_next;
               r_carry  <= add_cout;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  // Top nibble of the result comes straight from the adder this cycle.
                  r_out_valid <= 1'b1;
                  r_c         <= add_cout;
                  r_z         <= (w_result_next == '0);
                  r_v         <= (r_a[W-1] == (r_b[W-1] ^ r_sub)) && (add_sum[3] != r_a[W-1]);
               end
            end
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flag_c    = r_c;
   assign flag_z    = r_z;
   assign flag_v    = r_v;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_nibble_serial_alu_seq
// Brief   : Self-checking bench with a transaction-level add/sub model.
// Revision: 1.0
// ============================================================================
module tb_nibble_serial_alu_seq;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          op_sub = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic [3:0]    add_a;
   logic [3:0]    add_b;
   logic          add_cin;
   logic [3:0]    add_sum;
   logic          add_cout;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          flag_c;
   logic          flag_z;
   logic          flag_v;

   int n_checks = 0;
   int n_err    = 0;

   nibble_serial_alu_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op_sub(op_sub), .op_a(op_a), .op_b(op_b),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v)
   );

   // The external combinational 4-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: phase 0 idle, 1 busy on nibble m_k, 2 holding result.
   int m_phase  = 0;
   int m_k      = 0;
   int m_a      = 0;
   int m_b      = 0;
   int m_sub    = 0;
   int m_res    = 0;
   int m_c      = 0;
   int m_z      = 0;
   int m_v      = 0;
   int m_rvalid = 1;

   function automatic int beff_of(input int b, input int sub);
      return sub != 0 ? (~b & 32'hFFFF) : b;
   endfunction

   function automatic int to_signed(input int x);
      return (x >= 32768) ? x - 65536 : x;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_k = 0; m_res = 0; m_c = 0; m_z = 0; m_v = 0; m_rvalid = 1;
      end else begin
         case (m_phase)
            0: if (in_valid) begin
                  m_a = int'(op_a); m_b = int'(op_b); m_sub = int'(op_sub);
                  m_phase = 1; m_k = 0; m_rvalid = 0;
               end
            1: if (m_k == N - 1) begin
                  int full, exact;
                  full  = m_a + beff_of(m_b, m_sub) + m_sub;
                  m_res = full & 32'hFFFF;
                  m_c   = (full >> W) & 1;
                  m_z   = (m_res == 0) ? 1 : 0;
                  exact = m_sub != 0 ? to_signed(m_a) - to_signed(m_b)
                                     : to_signed(m_a) + to_signed(m_b);
                  m_v   = (exact > 32767 || exact < -32768) ? 1 : 0;
                  m_phase = 2; m_rvalid = 1;
               end else begin
                  m_k++;
               end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 1) begin
         int be, mask, cin;
         be   = beff_of(m_b, m_sub);
         mask = (1 << (4 * m_k)) - 1;
         cin  = (m_k == 0) ? m_sub : (((m_a & mask) + (be & mask) + m_sub) >> (4 * m_k)) & 1;
         chk("add_a", 32'(add_a), (m_a >> (4 * m_k)) & 15);
         chk("add_b", 32'(add_b), (be >> (4 * m_k)) & 15);
         chk("add_cin", 32'(add_cin), cin);
      end else begin
         chk("add_a_idle", 32'(add_a), 0);
         chk("add_b_idle", 32'(add_b), 0);
         chk("add_cin_idle", 32'(add_cin), 0);
      end
      if (m_rvalid != 0) begin
         chk("result", 32'(result), m_res);
         chk("flag_c", 32'(flag_c), m_c);
         chk("flag_z", 32'(flag_z), m_z);
         chk("flag_v", 32'(flag_v), m_v);
      end
   end

   task automatic wait_idle();
      int g = 0;
      while (in_ready !== 1'b1 && g < 50) begin
         @(posedge clk); #2; g++;
      end
      if (g >= 50) chk("idle_timeout", 32'(in_ready), 1);
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input int hold, input bit lit, input logic [15:0] er,
                         input logic ec, input logic ez, input logic ev);
      wait_idle();
      in_valid = 1'b1; op_a = a; op_b = b; op_sub = sub;
      out_ready = (hold == 0);
      @(posedge clk); #2;
      in_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); op_sub = 1'($urandom);
      repeat (N - 2) @(posedge clk);
      @(posedge clk); #1;
      if (lit) chk("lat_early", 32'(out_valid), 0);
      @(posedge clk); #1;
      if (lit) begin
         chk("lat_valid", 32'(out_valid), 1);
         chk("lit_result", 32'(result), 32'(er));
         chk("lit_c", 32'(flag_c), 32'(ec));
         chk("lit_z", 32'(flag_z), 32'(ez));
         chk("lit_v", 32'(flag_v), 32'(ev));
      end
      if (hold > 0) begin
         repeat (hold) begin
            in_valid = 1'b1; op_a = 16'($urandom);
            @(posedge clk); #1;
            if (lit) chk("hold_result", 32'(result), 32'(er));
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (lit) begin
         chk("release_valid", 32'(out_valid), 0);
         chk("release_ready", 32'(in_ready), 1);
      end
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_add_a", 32'(add_a), 0);
      chk("rst_flags", {29'd0, flag_c, flag_z, flag_v}, 0);
      #1 rst_n = 1'b1;

      run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1, 16'h2233, 1'b0, 1'b0, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b1, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, 1, 1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_op(16'h0007, 16'h0005, 1'b1, 0, 1, 16'h0002, 1'b1, 1'b0, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 2, 1, 16'h8000, 1'b0, 1'b0, 1'b1);
      run_op(16'h8000, 16'h0001, 1'b1, 0, 1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
      run_op(16'hA5A5, 16'h5A5A, 1'b0, 3, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      // Reset while the third nibble is on the adder.
      wait_idle();
      in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; op_sub = 1'b0; out_ready = 1'b1;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_add_a", 32'(add_a), 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", 32'(in_ready), 1);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_add", {23'd0, add_a, add_b, add_cin}, 0);
      chk("midrst_result", 32'(result), 0);
      chk("midrst_flags", {29'd0, flag_c, flag_z, flag_v}, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      run_op(16'h0001, 16'h0001, 1'b0, 0, 1, 16'h0002, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 300; i++) begin
         logic [15:0] ra, rb;
         int sel;
         sel = int'($urandom_range(0, 7));
         ra  = (sel == 0) ? 16'hFFFF : (sel == 1) ? 16'h8000 : 16'($urandom);
         rb  = (sel == 2) ? 16'h0000 : (sel == 3) ? 16'h7FFF : 16'($urandom);
         run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 0, 16'h0, 1'b0, 1'b0, 1'b0);
      end

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
